hyperram_target: RTL
====================

Name: hyperram_target

Overview:
Synthesizable HyperRAM responder (device-side model) that sits at the pad-signal level in place of `hyperram_io_ice40`. It connects directly to the `hyperram_ctrl` split-edge pad buses. It decodes the 48-bit command/address, counts initial latency, accepts masked writes into an internal array, and returns read data with an RWDS strobe. It is used for on-FPGA loopback and simulation of the controller without HyperRAM silicon. One `clk` cycle represents one HyperRAM CK period carrying two bytes: `_0` for the rising edge, `_1` for the falling edge.

Parameters:
- `MEM_AW`, 8: word (16-bit) address width of the internal array; depth is 2^MEM_AW.
- `LATENCY`, 6: initial-latency cycles between the last CA cycle and the first data cycle.

Ports:
- `clk`, in, 1: core clock; all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `hyperram_ce_to_pad_`, in, 1: chip select, active low.
- `hyperram_rst_to_pad_`, in, 1: device reset, active low.
- `hyperram_dq_to_pad_0`, in, 8: controller byte, rising edge.
- `hyperram_dq_to_pad_1`, in, 8: controller byte, falling edge.
- `hyperram_rwds_to_pad_0`, in, 1: write mask for the upper byte.
- `hyperram_rwds_to_pad_1`, in, 1: write mask for the lower byte.
- `hyperram_dq_dir`, in, 1: 1 means the controller drives DQ.
- `hyperram_rwds_dir`, in, 1: 1 means the controller drives RWDS.
- `hyperram_dq_from_pad_0`, out, 8: read byte, upper.
- `hyperram_dq_from_pad_1`, out, 8: read byte, lower.
- `hyperram_rwds_from_pad_0`, out, 1: RWDS, rising-edge half.
- `hyperram_rwds_from_pad_1`, out, 1: RWDS, falling-edge half.
- `target_busy`, out, 1: high whenever the state is not IDLE.
- `proto_err`, out, 1: sticky protocol-violation flag.

Behaviour:
- **Reset.** On `reset`, all outputs are 0 and the state is IDLE. `proto_err` is cleared and `cfg0` is set to 16'h8F1F. Array contents are preserved.
- **States:** IDLE, CA, LAT, WDATA, RDATA, REGWR, WAITCS.
- **CE deassert.** `ce_` high in any state forces IDLE on the next cycle, aborting the transaction. Words already written remain written.
- **Device reset.** `rst_to_pad_` low acts like `ce_` high and holds the state in IDLE.
- **CA capture.**
  - In IDLE, `ce_` sampled low at cycle t enters CA. The CA word is captured at t, t+1 and t+2.
  - Byte mapping: CA[47:40] = `dq_0`@t, CA[39:32] = `dq_1`@t, and so on down to CA[7:0] = `dq_1`@t+2.
  - CA[47]: 1 = read. CA[46]: 1 = register space. CA[45]: 1 = linear burst, 0 = wrapped burst.
  - Word address = {CA[44:16], CA[2:0]}, truncated to the `MEM_AW` LSBs.
- **Register write.** A register-space write goes CA -> REGWR. The word at t+3 is stored to `cfg0`, then the state goes to WAITCS. There is zero latency.
- **Memory access and register read.** These go CA -> LAT for `LATENCY` cycles (t+3 .. t+2+LATENCY). The state then goes to RDATA or WDATA. Data word n occupies cycle t+3+LATENCY+n.
- **WDATA.**
  - Each cycle writes {`dq_0`, `dq_1`} to the current address.
  - `rwds_to_pad_0` = 1 suppresses the write of bits [15:8].
  - `rwds_to_pad_1` = 1 suppresses the write of bits [7:0].
- **RDATA.**
  - `dq_from_pad_0` = word[15:8] and `dq_from_pad_1` = word[7:0].
  - `rwds_from_pad_0` = 1 and `rwds_from_pad_1` = 0.
  - Outputs are driven from registers. Memory is prefetched one word ahead so word 0 is valid exactly at t+3+LATENCY.
  - Outside RDATA (and CA when the optional feature is enabled), `dq_from_pad` and `rwds_from_pad` are 0.
- **Register read data.** Address 0 returns 16'h0C81 (ID0). Any other address returns `cfg0`.
- **Address advance.** After each data word:
  - Linear bursts increment modulo 2^MEM_AW.
  - Wrapped bursts increment within an aligned 16-word group: the low 4 bits wrap and the upper bits are fixed.
- **Burst length** is unbounded; the burst ends only when `ce_` rises.
- **Protocol errors.** `proto_err` is set and held until `reset` when any of the following occurs:
  - `dq_dir` = 0 during CA, REGWR or WDATA;
  - `dq_dir` = 1 during RDATA;
  - `rwds_dir` = 0 during WDATA.
- **Simultaneous events.** `ce_` rising in the same cycle as a data word: that word is still processed, then the state goes to IDLE.

Optional Feature:
`HRAM_TGT_DOUBLE_LAT_EN`
- Defined:
  - During the CA cycles the target drives `rwds_from_pad_0` and `rwds_from_pad_1` to 1, signalling 2x latency.
  - Memory-space and register-read accesses wait 2*LATENCY cycles in LAT.
- Undefined:
  - RWDS is 0 during CA.
  - Latency is LATENCY cycles.
- Register writes are unaffected in both cases.

Test Plan:
1. Memory write then read (LATENCY = 6): linear write of 16'hAA55 to word 0x10, then a read of 0x10 -> 16'hAA55 appears at t+9, with `rwds_from_pad_0` = 1 and `rwds_from_pad_1` = 0; `target_busy` falls the cycle after `ce_` rises.
2. Linear burst at the top of the array: 4-word write of 1, 2, 3, 4 starting at 0xFE (MEM_AW = 8), then read back -> 0xFE = 1, 0xFF = 2, 0x00 = 3, 0x01 = 4.
3. Wrapped burst: 4-word write starting at 0x1E (wrapped) -> words land at 0x1E, 0x1F, 0x10, 0x11; a linear read confirms this.
4. Byte-masked write:
   - Initial word AA55. Writing 16'h1234 with `rwds_to_pad_0` = 1 -> read gives 16'hAA34.
   - Writing 16'h1234 with `rwds_to_pad_1` = 1 -> read gives 16'h1255.
5. Aborts and reset:
   - `ce_` raised at t+4, mid-LAT, on a write -> IDLE the next cycle and memory is unchanged.
   - Async `reset` mid-RDATA -> outputs are 0 immediately and memory is retained.
6. Register space and protocol error:
   - Register write of 16'h8F17, then register read of address 1 -> 8F17; read of address 0 -> 0C81.
   - `dq_dir` = 0 during CA -> `proto_err` = 1 and stays set until `reset`.

Source files
------------

// File: rtl/hyperram_target.sv
// hyperram_target: pad-level HyperRAM responder that stands in for the HyperRAM
// device and its I/O block, so that the controller can be looped back on an FPGA
// or simulated. Each clk cycle is one HyperRAM CK period: "_0" signals are the
// rising-edge byte and "_1" signals are the falling-edge byte.
//
// Parameters:
//   MEM_AW  - word address width of the internal 16-bit array (MEM_AW >= 4)
//   LATENCY - initial latency in cycles between CA and data (LATENCY >= 1)
//
// Ports:
//   clk, reset                  - core clock, asynchronous active-high reset
//   hyperram_ce_to_pad_         - chip select, active low
//   hyperram_rst_to_pad_        - device reset, active low (acts like CE deasserted)
//   hyperram_dq_to_pad_0/1      - controller bytes (CA and write data)
//   hyperram_rwds_to_pad_0/1    - write masks for the upper and lower byte
//   hyperram_dq_dir/rwds_dir    - 1 = the controller drives DQ / RWDS
//   hyperram_dq_from_pad_0/1    - read data, upper and lower byte (registered)
//   hyperram_rwds_from_pad_0/1  - read strobe (registered)
//   target_busy                 - state is not idle
//   proto_err                   - sticky bus-direction violation flag
//
// Optional feature macro HRAM_TGT_DOUBLE_LAT_EN: when defined, RWDS is driven high
// during CA and memory/register-read accesses wait 2*LATENCY cycles.
module hyperram_target #(
    parameter int unsigned MEM_AW  = 8,
    parameter int unsigned LATENCY = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hyperram_ce_to_pad_,
    input  logic       hyperram_rst_to_pad_,
    input  logic [7:0] hyperram_dq_to_pad_0,
    input  logic [7:0] hyperram_dq_to_pad_1,
    input  logic       hyperram_rwds_to_pad_0,
    input  logic       hyperram_rwds_to_pad_1,
    input  logic       hyperram_dq_dir,
    input  logic       hyperram_rwds_dir,
    output logic [7:0] hyperram_dq_from_pad_0,
    output logic [7:0] hyperram_dq_from_pad_1,
    output logic       hyperram_rwds_from_pad_0,
    output logic       hyperram_rwds_from_pad_1,
    output logic       target_busy,
    output logic       proto_err
);

`ifdef HRAM_TGT_DOUBLE_LAT_EN
    localparam int unsigned LatCycles = 2 * LATENCY;
    localparam logic        CaRwds    = 1'b1;
`else
    localparam int unsigned LatCycles = LATENCY;
    localparam logic        CaRwds    = 1'b0;
`endif
    localparam int unsigned       CntW    = (LatCycles > 1) ? $clog2(LatCycles) : 1;
    localparam logic [CntW-1:0]   LatLast = CntW'(LatCycles - 1);
    localparam logic [MEM_AW-1:0] LowMask = MEM_AW'(15);
    localparam logic [15:0]       Id0     = 16'h0C81;
    localparam logic [15:0]       Cfg0Rst = 16'h8F1F;

    typedef enum logic [2:0] {
        StIdle,
        StCa,
        StLat,
        StWdata,
        StRdata,
        StRegwr,
        StWaitCs
    } state_t;

    state_t            r_state;
    logic [31:0]       r_ca_hi;      // CA[47:16]
    logic              r_ca_last;    // second CA cycle already captured
    logic              r_is_read;
    logic              r_is_reg;
    logic              r_linear;
    logic [MEM_AW-1:0] r_addr;       // next word to read, or word being written
    logic [CntW-1:0]   r_cnt;
    logic [15:0]       r_cfg0;
    logic              r_proto_err;
    logic [7:0]        r_dq0;
    logic [7:0]        r_dq1;
    logic              r_rwds0;
    logic              r_rwds1;
    logic [15:0]       r_mem [0:(1 << MEM_AW) - 1];

    logic              w_abort;
    logic [15:0]       w_word;
    logic [MEM_AW-1:0] w_ca_addr;
    logic [MEM_AW-1:0] w_inc;
    logic [MEM_AW-1:0] w_next_addr;
    logic [15:0]       w_rdata;
    logic              w_viol;

    assign w_abort = hyperram_ce_to_pad_ | ~hyperram_rst_to_pad_;
    assign w_word  = {hyperram_dq_to_pad_0, hyperram_dq_to_pad_1};

    // Word address {CA[44:16], CA[2:0]}; CA[2:0] arrives on the last CA cycle.
    assign w_ca_addr = MEM_AW'({r_ca_hi[28:0], w_word[2:0]});

    // Wrapped bursts stay inside an aligned 16-word group.
    assign w_inc       = r_addr + MEM_AW'(1);
    assign w_next_addr = r_linear ? w_inc : ((r_addr & ~LowMask) | (w_inc & LowMask));

    assign w_rdata = r_is_reg ? ((r_addr == '0) ? Id0 : r_cfg0) : r_mem[r_addr];

    // Direction checks apply only while a transaction is actually selected.
    always_comb begin
        w_viol = 1'b0;
        if (!w_abort) begin
            case (r_state)
                StIdle, StCa, StRegwr: w_viol = ~hyperram_dq_dir;
                StWdata:               w_viol = ~hyperram_dq_dir | ~hyperram_rwds_dir;
                StRdata:               w_viol = hyperram_dq_dir;
                default:               w_viol = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_ca_hi     <= '0;
            r_ca_last   <= 1'b0;
            r_is_read   <= 1'b0;
            r_is_reg    <= 1'b0;
            r_linear    <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_cfg0      <= Cfg0Rst;
            r_proto_err <= 1'b0;
            r_dq0       <= '0;
            r_dq1       <= '0;
            r_rwds0     <= 1'b0;
            r_rwds1     <= 1'b0;
        end else begin
            r_dq0   <= '0;
            r_dq1   <= '0;
            r_rwds0 <= 1'b0;
            r_rwds1 <= 1'b0;
            if (w_viol) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (!w_abort) begin
                        r_ca_hi[31:16] <= w_word;
                        r_ca_last      <= 1'b0;
                        r_rwds0        <= CaRwds;
                        r_rwds1        <= CaRwds;
                        r_state        <= StCa;
                    end
                end
                StCa: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                    end else if (!r_ca_last) begin
                        r_ca_hi[15:0] <= w_word;
                        r_ca_last     <= 1'b1;
                        r_rwds0       <= CaRwds;
                        r_rwds1       <= CaRwds;
                    end else begin
                        r_is_read <= r_ca_hi[31];
                        r_is_reg  <= r_ca_hi[30];
                        r_linear  <= r_ca_hi[29];
                        r_addr    <= w_ca_addr;
                        r_cnt     <= '0;
                        r_state   <= (!r_ca_hi[31] && r_ca_hi[30]) ? StRegwr : StLat;
                    end
                end
                StLat: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                    end else if (r_cnt == LatLast) begin
                        if (r_is_read) begin
                            // Prefetch word 0 so it is on the pads in the first data cycle.
                            r_dq0   <= w_rdata[15:8];
                            r_dq1   <= w_rdata[7:0];
                            r_rwds0 <= 1'b1;
                            r_addr  <= w_next_addr;
                            r_state <= StRdata;
                        end else begin
                            r_state <= StWdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StWdata: begin
                    r_addr <= w_next_addr;
                    if (w_abort) begin
                        r_state <= StIdle;
                    end
                end
                StRdata: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                    end else begin
                        r_dq0   <= w_rdata[15:8];
                        r_dq1   <= w_rdata[7:0];
                        r_rwds0 <= 1'b1;
                        r_addr  <= w_next_addr;
                    end
                end
                StRegwr: begin
                    r_cfg0  <= w_word;
                    r_state <= w_abort ? StIdle : StWaitCs;
                end
                StWaitCs: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Array has no reset so contents survive both resets; a word is written even
    // in the cycle where CE rises.
    always_ff @(posedge clk) begin
        if (r_state == StWdata) begin
            if (!hyperram_rwds_to_pad_0) begin
                r_mem[r_addr][15:8] <= hyperram_dq_to_pad_0;
            end
            if (!hyperram_rwds_to_pad_1) begin
                r_mem[r_addr][7:0] <= hyperram_dq_to_pad_1;
            end
        end
    end

    assign hyperram_dq_from_pad_0   = r_dq0;
    assign hyperram_dq_from_pad_1   = r_dq1;
    assign hyperram_rwds_from_pad_0 = r_rwds0;
    assign hyperram_rwds_from_pad_1 = r_rwds1;
    assign target_busy              = (r_state != StIdle);
    assign proto_err                = r_proto_err;

endmodule
